// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides.
// Every output is a function of registered state only, so no path runs from the inputs to the outputs.
module pipe_elastic_stage #(
  parameter int WIDTH = 223,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
    $error("pipe_elastic_stage: DEPTH must be within 2..16");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  // The wrap is explicit because DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  // in_ready and out_valid are precomputed from the next count, so a full buffer
  // stays closed on the cycle that pops it. That costs one bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (softReset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < CW'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  // A flush leaves the storage in place, so the head is masked while the buffer is empty.
  assign out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: directed vectors on a DEPTH=2 instance and
// a scoreboard-checked random stream on a DEPTH=3 instance.
module tb_pipe_elastic_stage;

  localparam int W = 223;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         softReset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         in_valid3 = 1'b0;
  logic         in_ready3;
  logic [W-1:0] in_data3 = '0;
  logic         out_valid3;
  logic         out_ready3 = 1'b0;
  logic [W-1:0] out_data3;
  logic [1:0]   count3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.WIDTH(W), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .softReset(softReset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_elastic_stage #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .softReset(softReset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .count(count3)
  );

  typedef struct {
    logic         rst;
    logic         srst;
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic [1:0]   ecount;
    logic         erdy;
    logic         evld;
    logic [W-1:0] edata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rst, input logic srst, input logic iv,
                              input logic [W-1:0] din, input logic ordy,
                              input logic [1:0] ec, input logic er, input logic ev,
                              input logic [W-1:0] ed);
    vec_t v;
    v.rst = rst; v.srst = srst; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ecount = ec; v.erdy = er; v.evld = ev; v.edata = ed;
    return v;
  endfunction

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] d;
    logic         hold;
    logic         m_rdy;
    logic         push;
    logic         pop;

    //          rst   srst  iv    din        ordy  cnt   rdy   vld   data
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 223'h0,    1'b0, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 223'h0,    1'b0, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 223'h0,    1'b0, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 223'hA,    1'b0, 2'd1, 1'b1, 1'b1, 223'hA);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 223'hB,    1'b0, 2'd2, 1'b0, 1'b1, 223'hA);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 223'hC,    1'b0, 2'd2, 1'b0, 1'b1, 223'hA);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 223'hC,    1'b1, 2'd1, 1'b1, 1'b1, 223'hB);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 223'h0,    1'b1, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 223'h0,    1'b1, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 223'h5,    1'b0, 2'd1, 1'b1, 1'b1, 223'h5);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 223'h6,    1'b1, 2'd1, 1'b1, 1'b1, 223'h6);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 223'h11,   1'b0, 2'd2, 1'b0, 1'b1, 223'h6);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 223'h99,   1'b1, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 223'h7,    1'b0, 2'd1, 1'b1, 1'b1, 223'h7);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 223'h8,    1'b1, 2'd0, 1'b1, 1'b0, 223'h0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 223'h0,    1'b0, 2'd0, 1'b1, 1'b0, 223'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      softReset = vecs[i].srst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk_n($sformatf("vec%0d count", i), int'(count), int'(vecs[i].ecount));
      chk_n($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vecs[i].erdy));
      chk_n($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].evld));
      chk_w($sformatf("vec%0d out_data", i), out_data, vecs[i].edata);
    end

    // Stream one entry per cycle through a single occupied slot.
    @(negedge clk);
    in_valid = 1'b1; in_data = 223'h100; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_w("stream prime data", out_data, 223'h100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d = W'(257 + i);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1;
      @(posedge clk); #1;
      chk_n($sformatf("stream%0d count", i), int'(count), 1);
      chk_n($sformatf("stream%0d in_ready", i), int'(in_ready), 1);
      chk_w($sformatf("stream%0d out_data", i), out_data, d);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_n("stream drain count", int'(count), 0);
    chk_w("stream drain data", out_data, 223'h0);
    @(negedge clk);
    out_ready = 1'b0;

    // DEPTH=3 random valid/ready traffic against a scoreboard queue.
    hold = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid3 = ($urandom_range(0, 3) != 0);
        in_data3  = rand_data();
      end
      out_ready3 = ($urandom_range(0, 2) != 0);
      #1;
      m_rdy = (q.size() < 3);
      chk_n("rnd in_ready", int'(in_ready3), int'(m_rdy));
      chk_n("rnd out_valid", int'(out_valid3), int'(q.size() != 0));
      if (q.size() != 0) chk_w("rnd out_data", out_data3, q[0]);
      else               chk_w("rnd out_data empty", out_data3, 223'h0);
      push = in_valid3 && m_rdy;
      pop  = (q.size() != 0) && out_ready3;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(in_data3);
      hold = in_valid3 && !push;
      @(posedge clk); #1;
      chk_n("rnd count", int'(count3), q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
